// File: rtl/button_debounce_if.sv
// Button-side signal bundle: raw pin input plus the cleaned level, event pulses and press count.
interface button_debounce_if;
    logic        btn_in;
    logic        btn_level;
    logic        press_pulse;
    logic        release_pulse;
    logic        long_press;
    logic [15:0] press_count;

    modport master (
        output btn_in,
        input  btn_level, press_pulse, release_pulse, long_press, press_count
    );

    modport slave (
        input  btn_in,
        output btn_level, press_pulse, release_pulse, long_press, press_count
    );
endinterface

// File: rtl/button_debounce.sv
// Synchronizes and debounces a raw push-button, producing a clean level,
// press/release/long-press pulses and a wrapping 16-bit press count.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    button_debounce_if.slave btn
);

    typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s_q, s_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             level_q, level_d;
    logic             fired_q, fired_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             long_press_q, long_press_d;
    logic [15:0]      press_count_q, press_count_d;

    logic accept;
    logic release_accept;
    logic fire;

    always_comb begin
        s1_d            = btn.btn_in;
        s_d             = s1_q;
        state_d         = state_q;
        deb_cnt_d       = '0;
        hold_cnt_d      = '0;
        level_d         = level_q;
        fired_d         = fired_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_press_d    = 1'b0;
        press_count_d   = press_count_q;

        accept         = (s_q != level_q) && (deb_cnt_q == DEB_LAST);
        release_accept = accept && level_q;

        // Any sample that agrees with the current level restarts the count.
        if (s_q != level_q && !accept) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end

        if (accept) begin
            level_d = s_q;
            if (s_q) begin
                press_pulse_d = 1'b1;
                press_count_d = press_count_q + 16'd1;
            end else begin
                release_pulse_d = 1'b1;
            end
        end

        // Hold counter saturates at its terminal value so a very long hold never re-fires.
        if (level_q) begin
            hold_cnt_d = (hold_cnt_q == LONG_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
        end

        fire         = level_q && (hold_cnt_q == LONG_LAST) && !fired_q && !release_accept;
        long_press_d = fire;
        if (release_accept) begin
            fired_d = 1'b0;
        end else if (fire) begin
            fired_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept)   state_d = PRESSED;
                else if (s_q) state_d = ARMING;
            end
            ARMING: begin
                if (accept)    state_d = PRESSED;
                else if (!s_q) state_d = IDLE;
            end
            PRESSED: begin
                if (accept)    state_d = IDLE;
                else if (!s_q) state_d = RELEASING;
            end
            RELEASING: begin
                if (accept)   state_d = IDLE;
                else if (s_q) state_d = PRESSED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            s1_q            <= 1'b0;
            s_q             <= 1'b0;
            deb_cnt_q       <= '0;
            hold_cnt_q      <= '0;
            level_q         <= 1'b0;
            fired_q         <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_press_q    <= 1'b0;
            press_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            s1_q            <= s1_d;
            s_q             <= s_d;
            deb_cnt_q       <= deb_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            level_q         <= level_d;
            fired_q         <= fired_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_press_q    <= long_press_d;
            press_count_q   <= press_count_d;
        end
    end

    assign btn.btn_level     = level_q;
    assign btn.press_pulse   = press_pulse_q;
    assign btn.release_pulse = release_pulse_q;
    assign btn.long_press    = long_press_q;
    assign btn.press_count   = press_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_debounce;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    button_debounce_if bif ();

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .CNT_W          (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (bif.slave)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int n_press, n_release, n_long, n_both;
    int last_long_cyc, rise_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, obs);
        end
    endtask

    // One clock edge, then sample outputs 1 time unit later and log events.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bif.press_pulse)   n_press++;
        if (bif.release_pulse) n_release++;
        if (bif.long_press) begin
            n_long++;
            last_long_cyc = cyc;
        end
        if (bif.press_pulse && bif.release_pulse) n_both++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_events();
        n_press = 0;
        n_release = 0;
        n_long = 0;
        last_long_cyc = -1;
    endtask

    logic [3:0] bounce_pat;

    initial begin
        n_both = 0;
        clear_events();
        bif.btn_in = 1'b1;
        reset = 1'b0;

        // Reset with button held, then release reset.
        ticks(3);
        check("rst_level", 32'(bif.btn_level), 32'd0);
        check("rst_press", 32'(bif.press_pulse), 32'd0);
        check("rst_release", 32'(bif.release_pulse), 32'd0);
        check("rst_long", 32'(bif.long_press), 32'd0);
        check("rst_count", 32'(bif.press_count), 32'd0);
        reset = 1'b1;
        ticks(5);
        check("rst_lvl_edge5", 32'(bif.btn_level), 32'd0);
        tick();
        check("rst_lvl_edge6", 32'(bif.btn_level), 32'd1);
        check("rst_press_edge6", 32'(bif.press_pulse), 32'd1);
        check("rst_count_1", 32'(bif.press_count), 32'd1);
        ticks(4);
        bif.btn_in = 1'b0;
        ticks(5);
        check("rst_rel_edge5", 32'(bif.btn_level), 32'd1);
        tick();
        check("rst_rel_pulse", 32'(bif.release_pulse), 32'd1);
        check("rst_rel_level", 32'(bif.btn_level), 32'd0);
        ticks(3);

        // Clean press held 10 cycles.
        clear_events();
        bif.btn_in = 1'b1;
        ticks(5);
        check("clean_lvl_edge5", 32'(bif.btn_level), 32'd0);
        tick();
        check("clean_lvl_edge6", 32'(bif.btn_level), 32'd1);
        check("clean_press", 32'(bif.press_pulse), 32'd1);
        check("clean_no_release", 32'(bif.release_pulse), 32'd0);
        check("clean_count", 32'(bif.press_count), 32'd2);
        tick();
        check("clean_press_1cyc", 32'(bif.press_pulse), 32'd0);
        ticks(3);
        bif.btn_in = 1'b0;
        ticks(6);
        check("clean_release", 32'(bif.release_pulse), 32'd1);
        ticks(3);
        check("clean_n_press", 32'(n_press), 32'd1);
        check("clean_n_release", 32'(n_release), 32'd1);

        // Bounce 1,1,1,0 for 40 cycles, then steady high.
        clear_events();
        bounce_pat = 4'b0111;
        for (int i = 0; i < 40; i++) begin
            bif.btn_in = bounce_pat[i % 4];
            tick();
        end
        check("bounce_level", 32'(bif.btn_level), 32'd0);
        check("bounce_no_press", 32'(n_press), 32'd0);
        check("bounce_no_release", 32'(n_release), 32'd0);
        bif.btn_in = 1'b1;
        ticks(5);
        check("bounce_lvl_edge5", 32'(bif.btn_level), 32'd0);
        tick();
        check("bounce_lvl_edge6", 32'(bif.btn_level), 32'd1);
        check("bounce_count", 32'(bif.press_count), 32'd3);
        bif.btn_in = 1'b0;
        ticks(8);

        // Long press: held 30 cycles.
        clear_events();
        bif.btn_in = 1'b1;
        ticks(6);
        rise_cyc = cyc;
        check("long_rise", 32'(bif.btn_level), 32'd1);
        ticks(24);
        bif.btn_in = 1'b0;
        ticks(5);
        check("long_rel_edge5", 32'(bif.release_pulse), 32'd0);
        tick();
        check("long_rel_edge6", 32'(bif.release_pulse), 32'd1);
        ticks(10);
        check("long_once", 32'(n_long), 32'd1);
        check("long_delay", 32'(last_long_cyc - rise_cyc), 32'd20);

        // Collision: release acceptance lands on hold_cnt == 19.
        clear_events();
        bif.btn_in = 1'b1;
        ticks(20);
        bif.btn_in = 1'b0;
        ticks(6);
        check("coll_release", 32'(bif.release_pulse), 32'd1);
        check("coll_long_now", 32'(bif.long_press), 32'd0);
        ticks(25);
        check("coll_no_long", 32'(n_long), 32'd0);

        // Counter wrap from 0xFFFF.
        force dut.press_count_q = 16'hFFFF;
        tick();
        release dut.press_count_q;
        check("wrap_preload", 32'(bif.press_count), 32'hFFFF);
        bif.btn_in = 1'b1;
        ticks(6);
        check("wrap_press", 32'(bif.press_pulse), 32'd1);
        check("wrap_count", 32'(bif.press_count), 32'h0000);
        bif.btn_in = 1'b0;
        ticks(8);

        // Reset during ARMING.
        clear_events();
        bif.btn_in = 1'b1;
        ticks(3);
        check("arm_deb_cnt", 32'(dut.deb_cnt_q), 32'd1);
        reset = 1'b0;
        tick();
        check("arm_rst_deb", 32'(dut.deb_cnt_q), 32'd0);
        check("arm_rst_level", 32'(bif.btn_level), 32'd0);
        bif.btn_in = 1'b0;
        reset = 1'b1;
        ticks(10);
        check("arm_no_press", 32'(n_press), 32'd0);
        check("arm_count", 32'(bif.press_count), 32'd0);
        check("never_both", 32'(n_both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Input-side counterpart of the LED blinker: turns a raw, bouncing, asynchronous push-button into clean single-clock events. Its outputs are a debounced level, one-cycle press and release pulses, a one-cycle long-press pulse and a running press count. It sits between a board pin and the LED/status logic, in the same `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive synchronized samples at the new value needed to accept a change (10 ms at 25 MHz); must be ≥ 1.
- `LONG_CYCLES`, default 25000000: cycles `btn_level` must stay high to fire `long_press` (1 s at 25 MHz); must be > `DEBOUNCE_CYCLES`.
- `CNT_W`, default 32: width of the internal debounce and hold counters; must hold `LONG_CYCLES`.
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `btn_in`, in, 1: raw button, active-high, asynchronous to `clk`.
- `btn_level`, out, 1: debounced button state.
- `press_pulse`, out, 1: one-cycle pulse when `btn_level` rises.
- `release_pulse`, out, 1: one-cycle pulse when `btn_level` falls.
- `long_press`, out, 1: one-cycle pulse once per hold that reaches `LONG_CYCLES`.
- `press_count`, out, 16: number of accepted presses; wraps around.

## Operation
- Synchronizer: a 2-flop chain `btn_in` → `s1` → `s`. Only `s` is used downstream.
- Debounce counter `deb_cnt`:
  - `s == btn_level`: clear `deb_cnt` to 0.
  - Else, `deb_cnt == DEBOUNCE_CYCLES-1`: `btn_level <= s`, clear `deb_cnt`, fire the matching edge pulse.
  - Else: `deb_cnt <= deb_cnt + 1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples restarts the count from 0.
- State machine:
  - IDLE (`btn_level`=0, `deb_cnt`=0) → ARMING when `s`=1.
  - ARMING → IDLE when `s`=0 before acceptance; ARMING → PRESSED on acceptance.
  - PRESSED (`btn_level`=1, `s`=1) → RELEASING when `s`=0.
  - RELEASING → PRESSED when `s`=1 before acceptance; RELEASING → IDLE on acceptance.
- Press acceptance (ARMING → PRESSED): `press_pulse`=1 and `press_count` increments; 0xFFFF wraps to 0x0000.
- Release acceptance (RELEASING → IDLE): `release_pulse`=1.
- Hold counter `hold_cnt`:
  - Increments every cycle `btn_level`=1, including in RELEASING; cleared to 0 when `btn_level`=0.
  - When `hold_cnt == LONG_CYCLES-1` and the `fired` flag is 0: `long_press`=1 and `fired` is set.
  - `fired` clears on release acceptance, so there is exactly one `long_press` per hold, with no auto-repeat.
  - Once `fired`=1, `hold_cnt` saturates at `LONG_CYCLES-1`; it never wraps.
- Simultaneous events:
  - If release acceptance and `hold_cnt == LONG_CYCLES-1` happen in the same cycle, release wins: `release_pulse`=1, `long_press`=0.
  - `press_pulse` and `release_pulse` are never high in the same cycle.
- Reset (`reset`=0 at a clock edge), whatever the state, including mid-debounce or mid-hold:
  - Registers cleared: `s1`, `s`, `deb_cnt`, `hold_cnt`, `fired`, `press_count`, all pulses.
  - State goes to IDLE.
  - A button held through reset is re-accepted as a new press `DEBOUNCE_CYCLES+2` cycles after release of reset.

## Timing
- Reset values of all outputs: `btn_level`=0, `press_pulse`=0, `release_pulse`=0, `long_press`=0, `press_count`=0.
- All outputs are registered; there is no combinational path from `btn_in`.
- `s` follows `btn_in` 2 edges after the edge that first samples the new value.
- `btn_level` changes `DEBOUNCE_CYCLES` edges after `s` changes, so total latency from the `btn_in` sample is `DEBOUNCE_CYCLES+2` edges.
- `press_pulse`, `release_pulse` and `press_count` update on the same edge as `btn_level`.
- `long_press` asserts `LONG_CYCLES` edges after `btn_level` rises.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20.
- Reset then idle: hold `reset`=0 for 3 cycles with `btn_in`=1, then release reset → all outputs 0 at release; `press_pulse` and `btn_level`=1 appear 6 edges later.
- Clean press: `btn_in` 0→1 and held 10 cycles → `btn_level`=1 at edge 6, `press_pulse` high 1 cycle, `press_count`=1, `release_pulse`=0.
- Bounce: `btn_in` pattern 1,1,1,0,1,1,1,0 repeating for 40 cycles → `btn_level` stays 0 and no pulses; then steady 1 → press accepted 6 edges after the steady level begins.
- Long press: hold 30 cycles → `long_press` exactly once, 20 edges after `btn_level` rises; release → `release_pulse` 6 edges later, no second `long_press`.
- Collision: release timed so acceptance lands on `hold_cnt`=19 → `release_pulse`=1, `long_press` never asserted.
- Wrap and mid-operation reset:
  - Preload 65535 presses (or force `press_count`=0xFFFF), then press once → `press_count`=0x0000.
  - Assert `reset` during ARMING → `deb_cnt` and `btn_level` clear, and the press is not counted.
